// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector (1..MAX_LEN bits, overlap/non-overlap, saturating match counter).
// Latency: match/progress/match_count register on the edge that accepts the completing bit (1 cycle).
// Backpressure: none; bits are taken whenever in_valid_i is high in RUN, and a cfg load discards that edge's bit.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   cfg_load_i            - strobe: latch cfg_pattern_i / cfg_len_i / cfg_overlap_i and clear history/counters
//   cfg_pattern_i         - pattern, bit [len-1] is the first expected bit, bit [0] the last
//   cfg_len_i             - pattern length (1..MAX_LEN accepted, anything else rejected)
//   cfg_overlap_i         - 1 = overlapping matches, 0 = history restarts after a match
//   in_valid_i, in_bit_i  - qualified serial input
//   count_clr_i           - clear match counter (wins over a same-edge match)
//   armed_o, cfg_err_o    - detector running / last load rejected
//   match_o               - one-cycle pulse per match
//   progress_o            - longest pattern prefix currently matched (< len)
//   match_count_o         - saturating match count
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               in_valid_i,
    input  logic               in_bit_i,
    input  logic               count_clr_i,
    output logic               armed_o,
    output logic               cfg_err_o,
    output logic               match_o,
    output logic [LEN_W-1:0]   progress_o,
    output logic [CNT_W-1:0]   match_count_o
);

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [MAX_LEN-1:0] ONES    = '1;
    localparam logic [LEN_W-1:0]   ACC_MAX = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    // Number of bits accepted since the last clear, saturating at MAX_LEN.
    logic [LEN_W-1:0]   acc_q, acc_d;
    logic               err_q, err_d;
    logic               match_q, match_d;
    logic [LEN_W-1:0]   prog_q, prog_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   acc_inc;
    logic [MAX_LEN-1:0] full_mask;
    logic [MAX_LEN-1:0] mask_k;
    logic               hit;
    logic [LEN_W-1:0]   prog_calc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
            prog_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            match_q <= match_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
        end
    end

    // Candidate history/progress as if in_bit_i were accepted this edge.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], in_bit_i};
        acc_inc    = (acc_q == ACC_MAX) ? acc_q : acc_q + LEN_W'(1);
        full_mask  = ONES >> (MAX_LEN - int'(len_q));
        hit        = (acc_inc >= len_q) &&
                     ((hist_shift & full_mask) == (pat_q & full_mask));

        // Longest k < len whose last k bits equal the first k pattern bits
        // (pattern[len-1 -: k]). Ascending scan, so the largest hit wins.
        // After a full match this is exactly the longest proper border.
        prog_calc = '0;
        mask_k    = '0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < int'(len_q) && k <= int'(acc_inc)) begin
                mask_k = ONES >> (MAX_LEN - k);
                if ((hist_shift & mask_k) == ((pat_q >> (int'(len_q) - k)) & mask_k)) begin
                    prog_calc = LEN_W'(k);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        acc_d   = acc_q;
        err_d   = err_q;
        match_d = 1'b0;
        prog_d  = prog_q;
        cnt_d   = cnt_q;

        if (cfg_load_i) begin
            // A load restarts everything; a same-edge input bit is dropped.
            pat_d  = cfg_pattern_i;
            len_d  = cfg_len_i;
            ovl_d  = cfg_overlap_i;
            hist_d = '0;
            acc_d  = '0;
            prog_d = '0;
            cnt_d  = '0;
            if ((cfg_len_i != '0) && (int'(cfg_len_i) <= MAX_LEN)) begin
                state_d = RUN;
                err_d   = 1'b0;
            end else begin
                state_d = UNCFG;
                err_d   = 1'b1;
            end
        end else begin
            if (state_q == RUN && in_valid_i) begin
                if (hit) begin
                    match_d = 1'b1;
                end
                if (hit && !ovl_q) begin
                    hist_d = '0;
                    acc_d  = '0;
                    prog_d = '0;
                end else begin
                    hist_d = hist_shift;
                    acc_d  = acc_inc;
                    prog_d = prog_calc;
                end
            end

            if (count_clr_i) begin
                cnt_d = '0;
            end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign armed_o       = (state_q == RUN);
    assign cfg_err_o     = err_q;
    assign match_o       = match_q;
    assign progress_o    = prog_q;
    assign match_count_o = cnt_q;

endmodule

// File: tb/tb_seq_det_prog.sv
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               count_clr;

    logic               armed, cfg_err, match;
    logic [LEN_W-1:0]   progress;
    logic [CNT_W-1:0]   match_count;

    logic               armed2, cfg_err2, match2;
    logic [LEN_W-1:0]   progress2;
    logic [1:0]         match_count2;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .in_valid_i(in_valid),
        .in_bit_i(in_bit), .count_clr_i(count_clr), .armed_o(armed), .cfg_err_o(cfg_err),
        .match_o(match), .progress_o(progress), .match_count_o(match_count)
    );

    // Narrow-counter instance for the saturation check; shares all inputs.
    seq_det_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .in_valid_i(in_valid),
        .in_bit_i(in_bit), .count_clr_i(count_clr), .armed_o(armed2), .cfg_err_o(cfg_err2),
        .match_o(match2), .progress_o(progress2), .match_count_o(match_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               ld;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ovl;
        logic               vld;
        logic               b;
        logic               clr;
        logic               e_armed;
        logic               e_err;
        logic               e_match;
        logic [LEN_W-1:0]   e_prog;
        logic [CNT_W-1:0]   e_cnt;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario 1: pattern 110101, overlap.
    int s1_bit [14] = '{1,1,0,1,0,1,0,1,1,1,0,1,0,1};
    int s1_m   [14] = '{0,0,0,0,0,1,0,0,0,0,0,0,0,1};
    int s1_p   [14] = '{1,2,3,4,5,1,0,1,2,2,3,4,5,1};
    // Scenario 2: pattern 1010 on 10101010.
    int s2_bit [8]  = '{1,0,1,0,1,0,1,0};
    int s2o_m  [8]  = '{0,0,0,1,0,1,0,1};
    int s2o_p  [8]  = '{1,2,3,2,3,2,3,2};
    int s2n_m  [8]  = '{0,0,0,1,0,0,0,1};
    int s2n_p  [8]  = '{1,2,3,0,1,2,3,0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                         input logic ovl, input logic vld, input logic b, input logic clr);
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = vld;
        in_bit      = b;
        count_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                                input logic ovl, input logic vld, input logic b, input logic clr,
                                input logic ea, input logic ee, input logic em,
                                input logic [LEN_W-1:0] ep, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.vld = vld; v.b = b; v.clr = clr;
        v.e_armed = ea; v.e_err = ee; v.e_match = em; v.e_prog = ep; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        int cnt;
        reset = 1'b1;
        cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; count_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_armed", armed, 0);
        chk("reset_err", cfg_err, 0);
        chk("reset_match", match, 0);
        chk("reset_prog", progress, 0);
        chk("reset_cnt", match_count, 0);
        reset = 1'b0;

        // ---- build vector table ----
        tbl.push_back(mk(1, 8'b0011_0101, 6, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            cnt += s1_m[i];
            tbl.push_back(mk(0, 8'b0011_0101, 6, 1, 1, 1'(s1_bit[i]), 0, 1, 0,
                             1'(s1_m[i]), LEN_W'(s1_p[i]), CNT_W'(cnt)));
        end
        tbl.push_back(mk(1, 8'b0000_1010, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += s2o_m[i];
            tbl.push_back(mk(0, 8'b0000_1010, 4, 1, 1, 1'(s2_bit[i]), 0, 1, 0,
                             1'(s2o_m[i]), LEN_W'(s2o_p[i]), CNT_W'(cnt)));
        end
        tbl.push_back(mk(1, 8'b0000_1010, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += s2n_m[i];
            tbl.push_back(mk(0, 8'b0000_1010, 4, 0, 1, 1'(s2_bit[i]), 0, 1, 0,
                             1'(s2n_m[i]), LEN_W'(s2n_p[i]), CNT_W'(cnt)));
        end
        // Rejected loads: len 0 then MAX_LEN+1; stream must not match.
        tbl.push_back(mk(1, 8'b0000_0001, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 8'b0000_0001, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hFF, LEN_W'(MAX_LEN + 1), 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 8'hFF, LEN_W'(MAX_LEN + 1), 1, 1, 1, 0, 0, 1, 0, 0, 0));
        // Valid load with a same-edge valid bit: the bit is discarded.
        tbl.push_back(mk(1, 8'b0000_0001, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'b0000_0001, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].vld, tbl[i].b, tbl[i].clr);
            chk($sformatf("vec%0d_armed", i), armed, tbl[i].e_armed);
            chk($sformatf("vec%0d_err", i), cfg_err, tbl[i].e_err);
            chk($sformatf("vec%0d_match", i), match, tbl[i].e_match);
            chk($sformatf("vec%0d_prog", i), progress, tbl[i].e_prog);
            chk($sformatf("vec%0d_cnt", i), match_count, tbl[i].e_cnt);
        end

        // ---- scenario 1 with an idle cycle after every bit ----
        drive(1, 8'b0011_0101, 6, 1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            cnt += s1_m[i];
            drive(0, 8'b0011_0101, 6, 1, 1, 1'(s1_bit[i]), 0);
            chk($sformatf("gap%0d_match", i), match, s1_m[i]);
            chk($sformatf("gap%0d_prog", i), progress, s1_p[i]);
            drive(0, 8'b0011_0101, 6, 1, 0, ~1'(s1_bit[i]), 0);
            chk($sformatf("gap%0d_idle_match", i), match, 0);
            chk($sformatf("gap%0d_idle_prog", i), progress, s1_p[i]);
            chk($sformatf("gap%0d_idle_cnt", i), match_count, cnt);
        end

        // ---- 2-bit counter saturation and clear-wins ----
        drive(1, 8'b0000_0001, 1, 1, 0, 0, 0);
        chk("sat_load_cnt", match_count2, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'b0000_0001, 1, 1, 1, 1, 0);
            chk($sformatf("sat%0d_match", i), match2, 1);
            chk($sformatf("sat%0d_prog", i), progress2, 0);
            chk($sformatf("sat%0d_cnt", i), match_count2, (i < 3) ? i + 1 : 3);
        end
        drive(0, 8'b0000_0001, 1, 1, 1, 1, 1);
        chk("clr_wins_match", match2, 1);
        chk("clr_wins_cnt", match_count2, 0);

        // ---- reset mid-stream on what would be the completing bit ----
        drive(1, 8'b0011_0101, 6, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 8'b0011_0101, 6, 1, 1, 1'(s1_bit[i]), 0);
        chk("pre_reset_prog", progress, 5);
        reset = 1'b1;
        drive(0, 8'b0011_0101, 6, 1, 1, 1, 0);
        chk("rst_match", match, 0);
        chk("rst_prog", progress, 0);
        chk("rst_armed", armed, 0);
        chk("rst_cnt", match_count, 0);
        reset = 1'b0;
        drive(1, 8'b0011_0101, 6, 1, 0, 0, 0);
        drive(0, 8'b0011_0101, 6, 1, 1, 1, 0);
        chk("post_rst_match", match, 0);
        chk("post_rst_prog", progress, 1);

        drive(0, '0, '0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial pattern detector: the next generation of the team's fixed-pattern Mealy detectors. It matches a runtime-loaded bit pattern of 1..MAX_LEN bits against a qualified serial input stream. It supports overlapping and non-overlapping match modes, reports match progress (the FSM-state equivalent), and keeps a saturating match counter. It sits between a serial bit source and control/status logic that consumes match pulses.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- LEN_W, 4: width of length/progress fields; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: match counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
- cfg_len  in  LEN_W  pattern length in bits.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- in_valid  in  1  in_bit is sampled on this edge.
- in_bit  in  1  serial data bit.
- count_clr  in  1  clear match_count.
- armed  out  1  configuration valid; detector running.
- cfg_err  out  1  last load was rejected.
- match  out  1  registered one-cycle pulse per detected match.
- progress  out  LEN_W  current match progress.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- States: UNCFG, RUN.
  - reset -> UNCFG.
  - In UNCFG: in_valid is ignored and armed = 0.
- cfg_load (either state):
  - Latches the pattern, length and mode.
  - Clears history, progress, match and match_count.
  - If 1 <= cfg_len <= MAX_LEN: cfg_err <= 0 and the state goes to RUN.
  - Otherwise: cfg_err <= 1 and the state goes to UNCFG.
- RUN, on each edge with in_valid = 1:
  - Shift in_bit into the history register (newest bit at the LSB).
  - A match occurs when at least cfg_len bits have been accepted since the last clear and history[len-1:0] == pattern[len-1:0].
- progress = largest k < len such that the last k accepted bits (since the last clear) equal the first k pattern bits.
  - Overlap mode: after a match, progress = longest proper prefix of the pattern that is also a suffix of it.
  - Non-overlap mode: a match clears the history, and progress <= 0.
- Edges with in_valid = 0 leave history and progress unchanged and drive match <= 0.
- match_count increments on each match and saturates at 2^CNT_W-1.
- count_clr sets match_count <= 0. If a match occurs on the same edge, the clear wins (result 0).
- cfg_load together with in_valid: the load wins and the bit is discarded.
- Reset values:
  - armed = 0, cfg_err = 0, match = 0, progress = 0, match_count = 0.
  - The pattern, length and history registers are also cleared.

## Timing
- All outputs are registered.
- match rises on the edge that accepts the completing bit and stays high for exactly one cycle, unless another match occurs on the next valid edge.
- Back-to-back valid bits can produce consecutive match cycles in overlap mode (e.g. pattern "11").
- progress and match_count update on the same edge as match.
- armed and cfg_err are valid from the edge after cfg_load.
- reset asserted mid-stream: all state is cleared on that edge. match never asserts on the edge where reset is sampled.
- A partially matched pattern is lost on cfg_load or reset.

## Test plan
- Load 6'b110101, len 6, overlap=1; stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1 with in_valid held high.
  - Required: match on bits 6 and 14 only; progress = 3 after bit 3; match_count = 2.
- Load 4'b1010, len 4; stream 1,0,1,0,1,0,1,0.
  - overlap=1: match on bits 4, 6 and 8, count 3.
  - overlap=0: match on bits 4 and 8, count 2; progress = 0 after bit 4.
- Repeat the first scenario with in_valid = 0 inserted between every bit.
  - Required: identical match sequence, and match is never high during gap cycles.
- Load cfg_len = 0, then cfg_len = MAX_LEN+1.
  - Required: cfg_err = 1, armed = 0, and an input stream produces no match.
  - Then a valid load gives cfg_err = 0 and armed = 1.
- CNT_W = 2, pattern "1" len 1, stream of 5 ones.
  - Required: count goes 1, 2, 3, 3, 3.
  - count_clr on the same edge as a match gives count = 0.
- Assert reset after bit 5 of 110101; deassert and send bit 1.
  - Required: no match, and progress = 1.
